reg_bank: RTL and testbench
===========================

// Module: reg_bank
// PURPOSE
//   32-entry general-purpose register file of the multicycle MIPS datapath.
//   Sits directly downstream of the write-register select mux: its WriteReg
//   input is that mux's 5-bit output (rt, rd, $31 or $29). Two combinational
//   read ports feed the A/B operand registers; one synchronous write port
//   commits write-back data.
// PARAMETERS
//   DATA_W   32        width of each register and of all data ports
//   SP_INIT  32'd227   value loaded into $29 ($sp) on reset
//   BYPASS   1         1: same-cycle write data forwarded to read ports; 0: no forwarding
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high
//   RegWrite   in   1       write enable for the current cycle
//   ReadReg1   in   5       read port 1 address (rs)
//   ReadReg2   in   5       read port 2 address (rt)
//   WriteReg   in   5       write address, from the write-register select mux
//   WriteData  in   DATA_W  write-back data
//   ReadData1  out  DATA_W  contents of ReadReg1
//   ReadData2  out  DATA_W  contents of ReadReg2
// BEHAVIOUR
//   - Storage: regs[0..31], DATA_W bits each, updated only on rising clk.
//   - Reset: at the clk edge with reset=1, every register is cleared to 0
//     except regs[29], which loads SP_INIT. Reset overrides any write in the
//     same cycle. After reset, ReadDataN = 0 for every address except 29.
//   - Write: at the clk edge with reset=0 and RegWrite=1,
//     regs[WriteReg] <= WriteData. Latency is 1 cycle: the value is visible
//     on the read ports from the following cycle.
//   - $0: writes with WriteReg=0 are discarded. ReadDataN is always 0 when
//     ReadRegN=0, independent of RegWrite, WriteData and BYPASS.
//   - Reads: combinational. ReadDataN = regs[ReadRegN] in the same cycle.
//   - Forwarding (BYPASS=1 only): if RegWrite=1, reset=0, WriteReg!=0 and
//     WriteReg==ReadRegN, then ReadDataN = WriteData in the same cycle.
//     Both ports are forwarded independently when both addresses match.
//   - BYPASS=0: the read ports return the old contents until the edge.
//   - Special write targets: WriteReg=31 and WriteReg=29 are ordinary
//     writes with no side effects. A write to $29 replaces SP_INIT until
//     the next reset.
//   - Reset mid-operation: an asserted reset discards any pending write and
//     returns the file to the reset image. The write completes only if
//     RegWrite is still high in a later cycle with reset=0.
//   - X-safety: with RegWrite=0, WriteReg and WriteData are don't-care and
//     no register changes.
// TESTING
//   1. Assert reset for 1 cycle -> ReadReg1=29 gives SP_INIT (227);
//      ReadReg2=5 gives 0; all 32 addresses swept, 0 except $29.
//   2. Write 0xDEADBEEF to reg 8, then read reg 8 on both ports -> both
//      return 0xDEADBEEF from the next cycle; reg 9 is still 0.
//   3. Write 0x12345678 with WriteReg=0 -> reading reg 0 returns 0 in the
//      same cycle and in all later cycles.
//   4. BYPASS=1: RegWrite=1, WriteReg=10, WriteData=0xA5A5A5A5, ReadReg1=10
//      -> ReadData1=0xA5A5A5A5 in the same cycle. With BYPASS=0 -> the old
//      value until the edge.
//   5. Drive RegWrite=1, WriteReg=31, WriteData=0x00400010 and assert reset
//      in the same cycle -> reg 31 reads 0 and reg 29 reads 227 afterwards.
//   6. Write reg 29=0x100 and reg 31=0x200 on consecutive cycles, then read
//      both together -> 0x100 and 0x200; after reset -> 227 and 0.

Source files
------------

// File: rtl/reg_bank.sv
// 32 x DATA_W register file for the multicycle MIPS datapath.
// It has two combinational read ports and one synchronous write port, with optional write-to-read forwarding.
module reg_bank #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(227),
    parameter int                 BYPASS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        ReadReg1,
    input  logic [4:0]        ReadReg2,
    input  logic [4:0]        WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];
    logic              write_en;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    // Writes to $0 are dropped, so regs_q[0] only ever holds its reset value of 0.
    assign write_en = RegWrite && (WriteReg != 5'd0);

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (write_en) begin
            regs_d[WriteReg] = WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == 29) ? SP_INIT : '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Forwarding is disabled while reset is asserted, because that write will never land.
    // $0 overrides everything else.
    always_comb begin
        read_data1 = regs_q[ReadReg1];
        if ((BYPASS != 0) && write_en && !reset && (WriteReg == ReadReg1)) begin
            read_data1 = WriteData;
        end
        if (ReadReg1 == 5'd0) begin
            read_data1 = '0;
        end
    end

    always_comb begin
        read_data2 = regs_q[ReadReg2];
        if ((BYPASS != 0) && write_en && !reset && (WriteReg == ReadReg2)) begin
            read_data2 = WriteData;
        end
        if (ReadReg2 == 5'd0) begin
            read_data2 = '0;
        end
    end

    assign ReadData1 = read_data1;
    assign ReadData2 = read_data2;

endmodule

// File: tb/tb_reg_bank.sv
// Directed testbench for reg_bank.
// It checks a forwarding instance and a non-forwarding instance side by side with the same stimulus.
module tb_reg_bank;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] rd1_nb;
    logic [31:0] rd2_nb;

    int total = 0;
    int bad   = 0;

    reg_bank #(.DATA_W(32), .SP_INIT(32'd227), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadData1(rd1), .ReadData2(rd2)
    );

    reg_bank #(.DATA_W(32), .SP_INIT(32'd227), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadData1(rd1_nb), .ReadData2(rd2_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        reset    = 1'b1;
        RegWrite = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(i);
            #1;
            exp = (i == 29) ? 32'd227 : 32'd0;
            total++;
            if (rd1 !== exp) begin
                bad++;
                $display("[TB] FAIL reset_rd1[%0d]: got %h expected %h", i, rd1, exp);
            end
            total++;
            if (rd2_nb !== exp) begin
                bad++;
                $display("[TB] FAIL reset_rd2_nb[%0d]: got %h expected %h", i, rd2_nb, exp);
            end
        end
        ReadReg1 = 5'd29;
        ReadReg2 = 5'd5;
        #1;
        total++;
        if (rd1 !== 32'd227 || rd2 !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_sp: got %h/%h expected 000000e3/00000000", rd1, rd2);
        end
    endtask

    task automatic test_write();
        RegWrite  = 1'b1;
        WriteReg  = 5'd8;
        WriteData = 32'hDEADBEEF;
        ReadReg1  = 5'd8;
        ReadReg2  = 5'd9;
        #1;
        total++;
        if (rd1_nb !== 32'd0) begin
            bad++;
            $display("[TB] FAIL write_pre_edge_nb: got %h expected 00000000", rd1_nb);
        end
        tick();
        RegWrite = 1'b0;
        ReadReg2 = 5'd8;
        #1;
        total++;
        if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL write_r8: got %h/%h expected deadbeef", rd1, rd2);
        end
        total++;
        if (rd1_nb !== 32'hDEADBEEF || rd2_nb !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL write_r8_nb: got %h/%h expected deadbeef", rd1_nb, rd2_nb);
        end
        ReadReg2 = 5'd9;
        #1;
        total++;
        if (rd2 !== 32'd0) begin
            bad++;
            $display("[TB] FAIL write_r9: got %h expected 00000000", rd2);
        end
    endtask

    task automatic test_zero();
        RegWrite  = 1'b1;
        WriteReg  = 5'd0;
        WriteData = 32'h12345678;
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd0;
        #1;
        total++;
        if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
            bad++;
            $display("[TB] FAIL zero_same_cycle: got %h/%h expected 0", rd1, rd2);
        end
        tick();
        total++;
        if (rd1 !== 32'd0 || rd1_nb !== 32'd0) begin
            bad++;
            $display("[TB] FAIL zero_after_edge: got %h/%h expected 0", rd1, rd1_nb);
        end
        RegWrite = 1'b0;
        tick();
        total++;
        if (rd2 !== 32'd0 || rd2_nb !== 32'd0) begin
            bad++;
            $display("[TB] FAIL zero_later: got %h/%h expected 0", rd2, rd2_nb);
        end
    endtask

    task automatic test_bypass();
        RegWrite  = 1'b1;
        WriteReg  = 5'd10;
        WriteData = 32'hA5A5A5A5;
        ReadReg1  = 5'd10;
        ReadReg2  = 5'd10;
        #1;
        total++;
        if (rd1 !== 32'hA5A5A5A5 || rd2 !== 32'hA5A5A5A5) begin
            bad++;
            $display("[TB] FAIL bypass_fwd: got %h/%h expected a5a5a5a5", rd1, rd2);
        end
        total++;
        if (rd1_nb !== 32'd0 || rd2_nb !== 32'd0) begin
            bad++;
            $display("[TB] FAIL bypass_off_old: got %h/%h expected 0", rd1_nb, rd2_nb);
        end
        tick();
        total++;
        if (rd1_nb !== 32'hA5A5A5A5) begin
            bad++;
            $display("[TB] FAIL bypass_off_after: got %h expected a5a5a5a5", rd1_nb);
        end
        RegWrite  = 1'b0;
        WriteData = 32'hFFFF0000;
        #1;
        total++;
        if (rd1 !== 32'hA5A5A5A5) begin
            bad++;
            $display("[TB] FAIL no_fwd_when_idle: got %h expected a5a5a5a5", rd1);
        end
        tick();
        total++;
        if (rd1 !== 32'hA5A5A5A5 || rd2_nb !== 32'hA5A5A5A5) begin
            bad++;
            $display("[TB] FAIL idle_no_write: got %h/%h expected a5a5a5a5", rd1, rd2_nb);
        end
    endtask

    task automatic test_back_to_back();
        RegWrite  = 1'b1;
        WriteReg  = 5'd29;
        WriteData = 32'h100;
        tick();
        WriteReg  = 5'd31;
        WriteData = 32'h200;
        ReadReg1  = 5'd29;
        ReadReg2  = 5'd31;
        #1;
        total++;
        if (rd1 !== 32'h100 || rd2 !== 32'h200) begin
            bad++;
            $display("[TB] FAIL b2b_mid: got %h/%h expected 100/200", rd1, rd2);
        end
        total++;
        if (rd2_nb !== 32'd0) begin
            bad++;
            $display("[TB] FAIL b2b_mid_nb: got %h expected 0", rd2_nb);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        total++;
        if (rd1_nb !== 32'h100 || rd2_nb !== 32'h200) begin
            bad++;
            $display("[TB] FAIL b2b_final: got %h/%h expected 100/200", rd1_nb, rd2_nb);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (rd1 !== 32'd227 || rd2 !== 32'd0) begin
            bad++;
            $display("[TB] FAIL b2b_reset: got %h/%h expected 000000e3/0", rd1, rd2);
        end
    endtask

    task automatic test_reset_collision();
        reset     = 1'b1;
        RegWrite  = 1'b1;
        WriteReg  = 5'd31;
        WriteData = 32'h00400010;
        ReadReg1  = 5'd31;
        ReadReg2  = 5'd29;
        #1;
        total++;
        if (rd1 !== 32'd0) begin
            bad++;
            $display("[TB] FAIL coll_no_fwd: got %h expected 0", rd1);
        end
        tick();
        reset    = 1'b0;
        RegWrite = 1'b0;
        #1;
        total++;
        if (rd1 !== 32'd0 || rd2 !== 32'd227) begin
            bad++;
            $display("[TB] FAIL coll_after: got %h/%h expected 0/000000e3", rd1, rd2);
        end
        RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
        #1;
        total++;
        if (rd1_nb !== 32'h00400010 || rd2_nb !== 32'd227) begin
            bad++;
            $display("[TB] FAIL coll_retry: got %h/%h expected 00400010/000000e3", rd1_nb, rd2_nb);
        end
    endtask

    initial begin
        reset     = 1'b1;
        RegWrite  = 1'b0;
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd0;
        WriteReg  = 5'd0;
        WriteData = 32'd0;
        test_reset();
        test_write();
        test_zero();
        test_bypass();
        test_back_to_back();
        test_reset_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
